hc_accumulator: RTL and testbench

//  Downstream consumer of the 16-bit Han-Carlson adder: accepts a valid/ready stream of 16-bit

---
 rtl/hc_accumulator.sv | 181 ++++++++++++++++++
 tb/tb_hc_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_accumulator.sv
// hc_accumulator: sums a programmed number of 16-bit unsigned samples from a valid/ready
// stream using a single 16-bit Han-Carlson prefix adder, and presents the block sum, a
// sticky carry-out flag and the beat count on a valid/ready result port.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      begin a block (only looked at in idle)
//   use_def_i    with start_i: 1 = block length DEF_LEN, 0 = len_i
//   len_i        samples per block, latched on an accepted start
//   clear_i      synchronous abort, highest priority in every state
//   in_valid_i   sample valid
//   in_data_i    16-bit unsigned sample
//   in_ready_o   high while accumulating
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  result consumer ready
//   out_sum_o    block sum modulo 2**16
//   out_ovf_o    any addition in the block carried out of bit 15
//   out_count_o  number of samples accumulated
//   busy_o       high while accumulating or holding a result
module hc_accumulator #(
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned DEF_LEN = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             use_def_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             clear_i,
   input  logic             in_valid_i,
   input  logic [15:0]      in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [15:0]      out_sum_o,
   output logic             out_ovf_o,
   output logic [LEN_W-1:0] out_count_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e           state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      sum_q, sum_d;
   logic             sum_ovf_q, sum_ovf_d;
   logic [LEN_W-1:0] count_q, count_d;

   // Han-Carlson adder: acc_q + in_data_i
   logic [15:0] hc_pp, hc_g, hc_p, hc_gs, hc_ps, hc_sum;
   logic        hc_cout;

   always_comb begin
      hc_pp = acc_q ^ in_data_i;
      hc_g  = acc_q & in_data_i;
      hc_p  = hc_pp;
      hc_gs = '0;
      hc_ps = '0;
      // Odd bits pick up their even neighbour first.
      for (int i = 1; i < 16; i += 2) begin
         hc_g[i] = hc_g[i] | (hc_p[i] & hc_g[i-1]);
         hc_p[i] = hc_p[i] & hc_p[i-1];
      end
      // Kogge-Stone over odd bits only.
      for (int d = 2; d < 16; d = d * 2) begin
         hc_gs = hc_g;
         hc_ps = hc_p;
         for (int i = 1; i < 16; i += 2) begin
            if (i > d) begin
               hc_g[i] = hc_gs[i] | (hc_ps[i] & hc_gs[i-d]);
               hc_p[i] = hc_ps[i] & hc_ps[i-d];
            end
         end
      end
      // Even bits fix up from the completed odd prefix below them.
      for (int i = 2; i < 16; i += 2) begin
         hc_g[i] = hc_g[i] | (hc_p[i] & hc_g[i-1]);
      end
      hc_sum[0] = hc_pp[0];
      for (int i = 1; i < 16; i++) begin
         hc_sum[i] = hc_pp[i] ^ hc_g[i-1];
      end
      hc_cout = hc_g[15];
   end

   logic [LEN_W-1:0] start_len;
   logic [LEN_W-1:0] cnt_inc;

   assign start_len = use_def_i ? LEN_W'(DEF_LEN) : len_i;
   assign cnt_inc   = cnt_q + LEN_W'(1);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      sum_d     = sum_q;
      sum_ovf_d = sum_ovf_q;
      count_d   = count_q;
      if (clear_i) begin
         // Drops any same-cycle sample or result handshake.
         state_d = StIdle;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  len_d = start_len;
                  acc_d = '0;
                  cnt_d = '0;
                  ovf_d = 1'b0;
                  if (start_len != '0) begin
                     state_d = StAccum;
                  end else begin
                     state_d   = StDone;
                     sum_d     = '0;
                     sum_ovf_d = 1'b0;
                     count_d   = '0;
                  end
               end
            end
            StAccum: begin
               if (in_valid_i) begin
                  acc_d = hc_sum;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | hc_cout;
                  if (cnt_inc == len_q) begin
                     state_d   = StDone;
                     sum_d     = hc_sum;
                     sum_ovf_d = ovf_q | hc_cout;
                     count_d   = cnt_inc;
                  end
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
         sum_q     <= '0;
         sum_ovf_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         ovf_q     <= ovf_d;
         sum_q     <= sum_d;
         sum_ovf_q <= sum_ovf_d;
         count_q   <= count_d;
      end
   end

   assign in_ready_o  = (state_q == StAccum);
   assign out_valid_o = (state_q == StDone);
   assign busy_o      = (state_q != StIdle);
   assign out_sum_o   = sum_q;
   assign out_ovf_o   = sum_ovf_q;
   assign out_count_o = count_q;

endmodule

// File: tb/tb_hc_accumulator.sv
// tb_hc_accumulator: directed and randomized stimulus for hc_accumulator, checked against an
// arithmetic reference model of a block sum (integer addition, wrap at 2**16, sticky carry).
module tb_hc_accumulator;

   localparam int unsigned LEN_W   = 8;
   localparam int unsigned DEF_LEN = 8;

   logic             clk, rst_n;
   logic             start, use_def, clear;
   logic [LEN_W-1:0] len;
   logic             in_valid, in_ready;
   logic [15:0]      in_data;
   logic             out_valid, out_ready;
   logic [15:0]      out_sum;
   logic             out_ovf;
   logic [LEN_W-1:0] out_count;
   logic             busy;

   int tests = 0;
   int fails = 0;

   logic [15:0] q[$];

   hc_accumulator #(
      .LEN_W   (LEN_W),
      .DEF_LEN (DEF_LEN)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .use_def_i   (use_def),
      .len_i       (len),
      .clear_i     (clear),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .out_ovf_o   (out_ovf),
      .out_count_o (out_count),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer sum, wrap at 2**16, sticky flag on any carry out.
   function automatic void model(input logic [15:0] d[$], output logic [15:0] s,
                                 output logic o);
      int acc;
      acc = 0;
      o   = 1'b0;
      foreach (d[i]) begin
         acc = acc + int'(d[i]);
         if (acc > 65535) begin
            o   = 1'b1;
            acc = acc - 65536;
         end
      end
      s = acc[15:0];
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic start_blk(input int l, input bit ud);
      start   = 1'b1;
      use_def = ud;
      len     = LEN_W'(l);
      @(negedge clk);
      start   = 1'b0;
      use_def = 1'b0;
      len     = LEN_W'($urandom);
   endtask

   // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
   task automatic send(input logic [15:0] d[$], input int mode);
      int idx = 0;
      int cyc = 0;
      bit acc;
      while (idx < d.size() && cyc < 4 * d.size() + 50) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = in_valid ? d[idx] : 16'($urandom);
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      if (idx < d.size()) chk("send_timeout", 32'(idx), 32'(d.size()));
   endtask

   task automatic finish(input logic [15:0] d[$], input int hold, input bit poke);
      logic [15:0] s;
      logic        o;
      model(d, s, o);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_sum", 32'(out_sum), 32'(s));
      chk("out_ovf", 32'(out_ovf), 32'(o));
      chk("out_count", 32'(out_count), 32'(d.size()));
      chk("done_in_ready", 32'(in_ready), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
         start = poke;
         len   = LEN_W'($urandom_range(1, 5));
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(out_sum), 32'(s));
         chk("hold_count", 32'(out_count), 32'(d.size()));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("consumed_valid", 32'(out_valid), 32'd0);
      chk("consumed_busy", 32'(busy), 32'd0);
      chk("retained_sum", 32'(out_sum), 32'(s));
   endtask

   task automatic run_block(input int l, input bit ud, input logic [15:0] d[$], input int mode,
                            input int hold);
      start_blk(l, ud);
      send(d, mode);
      finish(d, hold, 1'b0);
   endtask

   initial begin
      int l;
      rst_n = 1'b0; start = 1'b0; use_def = 1'b0; len = '0; clear = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: len 4, back-to-back
      q = '{16'd1, 16'd2, 16'd3, 16'd4};
      run_block(4, 1'b0, q, 0, 0);

      // 2: overflow, then flag not carried over
      q = '{16'hFFFF, 16'h0002};
      run_block(2, 1'b0, q, 0, 0);
      q = '{16'h0005};
      run_block(1, 1'b0, q, 0, 0);

      // 3: default length, alternating valid; len input is junk
      q = {};
      repeat (8) q.push_back(16'h1000);
      run_block(3, 1'b1, q, 1, 0);

      // 4: held result with start pokes, then nothing starts
      q = '{16'($urandom), 16'($urandom), 16'($urandom)};
      start_blk(3, 1'b0);
      send(q, 0);
      finish(q, 5, 1'b1);
      @(negedge clk);
      chk("no_restart_busy", 32'(busy), 32'd0);

      // 5: clear with a same-cycle sample
      start_blk(3, 1'b0);
      q = '{16'd10, 16'd20};
      send(q, 0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd9;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clear_valid", 32'(out_valid), 32'd0);
      chk("clear_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("clear_valid2", 32'(out_valid), 32'd0);
      q = '{16'd7};
      run_block(1, 1'b0, q, 0, 0);
      // clear beats start in idle
      start = 1'b1; clear = 1'b1; len = LEN_W'(4);
      @(negedge clk);
      start = 1'b0; clear = 1'b0;
      chk("clear_start_busy", 32'(busy), 32'd0);
      chk("clear_start_in_ready", 32'(in_ready), 32'd0);

      // 6: zero length goes straight to a zero result
      start_blk(0, 1'b0);
      q = {};
      finish(q, 0, 1'b0);

      // clear while holding a result, together with out_ready
      q = '{16'h8000, 16'h8000};
      start_blk(2, 1'b0);
      send(q, 0);
      clear = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      clear = 1'b0; out_ready = 1'b0;
      chk("clear_done_valid", 32'(out_valid), 32'd0);
      chk("clear_done_busy", 32'(busy), 32'd0);

      // randomized blocks
      for (int b = 0; b < 12; b++) begin
         l = int'($urandom_range(1, 16));
         q = {};
         for (int i = 0; i < l; i++) begin
            q.push_back($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255)));
         end
         run_block(l, 1'b0, q, 2, int'($urandom_range(0, 3)));
      end

      // maximum block length
      q = {};
      for (int i = 0; i < 255; i++) q.push_back(16'($urandom_range(0, 511)));
      run_block(255, 1'b0, q, 0, 0);

      // reset mid-block after a nonzero result
      q = '{16'h1234};
      run_block(1, 1'b0, q, 0, 0);
      start_blk(5, 1'b0);
      q = '{16'd3, 16'd4};
      send(q, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_sum", 32'(out_sum), 32'd0);
      chk("arst_count", 32'(out_count), 32'd0);
      chk("arst_ovf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q = '{16'hFFFF, 16'h0001, 16'h0001};
      run_block(3, 1'b0, q, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
